// File: rtl/bch_gf13_pkg.sv
// bch_gf13_pkg: GF(2^13) constants, element type, alpha-power multiply and syndrome FSM states
package bch_gf13_pkg;
  localparam int GF_M = 13;
  localparam logic [13:0] GF_POLY = 14'h201B;
  typedef logic [GF_M-1:0] gf_elem_t;
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  // j is a constant at every call site, so the xtime chain folds into a fixed XOR network
  function automatic gf_elem_t gf_mul_alpha_pow(gf_elem_t a, int j);
    gf_elem_t r;
    r = a;
    for (int i = 0; i < j; i++) r = r[GF_M-1] ? ((r << 1) ^ GF_POLY[GF_M-1:0]) : (r << 1);
    return r;
  endfunction
endpackage

// File: rtl/bch_syn_cell.sv
// bch_syn_cell: one Horner syndrome register S_J <= S_J*alpha^J ^ din, with first-bit load
module bch_syn_cell
  import bch_gf13_pkg::*;
#(
  parameter int J = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     upd,
  input  logic     din,
  output gf_elem_t s,
  output gf_elem_t s_nxt
);
  assign s_nxt = load ? {12'b0, din} : upd ? gf_mul_alpha_pow(s, J) ^ {12'b0, din} : s;
  always_ff @(posedge clk)
    if (rst) s <= '0;
    else s <= s_nxt;
endmodule

// File: rtl/bch_syndrome_ctrl.sv
// bch_syndrome_ctrl: serial BCH syndrome engine and result handoff sequencer.
// Optional BCH_SYN_LAST_CHECK_EN adds in_last/frame_err framing checks.
module bch_syndrome_ctrl
  import bch_gf13_pkg::*;
#(
  parameter int N_LEN = 8191,
  parameter int NSYN  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_bit,
`ifdef BCH_SYN_LAST_CHECK_EN
  input  logic                 in_last,
  output logic                 frame_err,
`endif
  output logic                 syn_valid,
  input  logic                 syn_ready,
  output logic [13*NSYN-1:0]   syn_data,
  output logic                 syn_zero,
  output logic                 busy
);
  localparam int CW = $clog2(N_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(N_LEN - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [13*NSYN-1:0] syn_nxt;
  logic acc, fin, stop, enter_out;
  assign in_ready  = state != OUT;
  assign syn_valid = state == OUT;
  assign busy      = state != IDLE;
  assign acc       = in_valid && in_ready;
  // the bit currently offered would be bit number N_LEN of the frame
  assign fin       = state == IDLE ? N_LEN == 1 : cnt == LAST;
`ifdef BCH_SYN_LAST_CHECK_EN
  assign stop      = fin || in_last;
`else
  assign stop      = fin;
`endif
  assign enter_out = state != OUT && state_n == OUT;
  for (genvar j = 0; j < NSYN; j++) begin : g_cell
    bch_syn_cell #(.J(j + 1)) u_cell (
      .clk   (clk),
      .rst   (rst),
      .load  (acc && state == IDLE),
      .upd   (acc && state == ACC),
      .din   (in_bit),
      .s     (syn_data[13*j +: 13]),
      .s_nxt (syn_nxt[13*j +: 13])
    );
  end
  always_comb begin
    state_n = state;
    if (state == OUT) state_n = syn_ready ? IDLE : OUT;
    else if (acc) state_n = stop ? OUT : ACC;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      syn_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) cnt <= state == IDLE ? CW'(1) : cnt + CW'(1);
      if (enter_out) syn_zero <= syn_nxt == '0;
      else if (syn_valid && syn_ready) syn_zero <= 1'b0;
    end
`ifdef BCH_SYN_LAST_CHECK_EN
  // entering OUT means fin or in_last; exactly one of them set is an early or missing last
  always_ff @(posedge clk)
    if (rst) frame_err <= 1'b0;
    else if (enter_out) frame_err <= in_last ^ fin;
    else if (syn_valid && syn_ready) frame_err <= 1'b0;
`endif
endmodule

// File: tb/tb_bch_syndrome_ctrl.sv
// tb_bch_syndrome_ctrl: scoreboard bench for bch_syndrome_ctrl with N_LEN=15, NSYN=8.
// Build with BCH_SYN_LAST_CHECK_EN defined to exercise the in_last/frame_err checks.
module tb_bch_syndrome_ctrl;
  localparam int N = 15;
  logic clk = 0, rst = 1, in_valid = 0, in_bit = 0, syn_ready = 0;
  logic in_ready, syn_valid, syn_zero, busy;
  logic [103:0] syn_data;
`ifdef BCH_SYN_LAST_CHECK_EN
  logic in_last = 0, frame_err;
`endif
  int asserts = 0, fails = 0;
  logic [12:0] pw [8191];
  logic [105:0] q[$];

  bch_syndrome_ctrl #(.N_LEN(N), .NSYN(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
`ifdef BCH_SYN_LAST_CHECK_EN
    .in_last(in_last), .frame_err(frame_err),
`endif
    .syn_valid(syn_valid), .syn_ready(syn_ready), .syn_data(syn_data),
    .syn_zero(syn_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // direct evaluation r(alpha^j) = XOR of alpha^(d*j) over set coefficients of degree d
  function automatic logic [103:0] model(input logic [14:0] v, input int n);
    logic [103:0] r;
    r = '0;
    for (int j = 1; j <= 8; j++)
      for (int i = 0; i < n; i++)
        if (v[i]) r[13*(j-1) +: 13] ^= pw[(i*j) % 8191];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [14:0] v, input int n, input bit gaps, input int last_at, input bit err);
    logic [103:0] m;
    m = model(v, n);
    q.push_back({err, m == '0, m});
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin in_valid = 0; tick(); end
      in_valid = 1; in_bit = v[i];
`ifdef BCH_SYN_LAST_CHECK_EN
      in_last = (n - i == last_at);
`endif
      asserts++;
      if (in_ready !== 1'b1 || syn_valid !== 1'b0) begin
        fails++; $display("FAIL send_bit%0d: in_ready=%b syn_valid=%b, want 1 0", n - 1 - i, in_ready, syn_valid);
      end
      tick();
    end
    in_valid = 0; in_bit = 0;
`ifdef BCH_SYN_LAST_CHECK_EN
    in_last = 0;
`endif
  endtask

  task automatic collect(input int stall, input string nm);
    logic [105:0] e;
    logic [103:0] held;
    for (int k = 0; k < 40 && syn_valid !== 1'b1; k++) tick();
    e = q.pop_front();
    asserts++;
    if (syn_valid !== 1'b1) begin
      fails++; $display("FAIL %s_timeout: syn_valid=%b, want 1", nm, syn_valid);
      return;
    end
    asserts++;
    if (syn_data !== e[103:0] || syn_zero !== e[104] || in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_result: data=%h zero=%b rdy=%b busy=%b, want data=%h zero=%b rdy=0 busy=1",
               nm, syn_data, syn_zero, in_ready, busy, e[103:0], e[104]);
    end
`ifdef BCH_SYN_LAST_CHECK_EN
    asserts++;
    if (frame_err !== e[105]) begin fails++; $display("FAIL %s_frame_err: got %b want %b", nm, frame_err, e[105]); end
`endif
    held = e[103:0];
    syn_ready = 0;
    repeat (stall) begin
      tick();
      asserts++;
      if (syn_valid !== 1'b1 || syn_data !== held || in_ready !== 1'b0) begin
        fails++; $display("FAIL %s_stall: valid=%b data=%h rdy=%b, want 1 %h 0", nm, syn_valid, syn_data, in_ready, held);
      end
    end
    syn_ready = 1; tick(); syn_ready = 0;
    asserts++;
    if (syn_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL %s_handoff: valid=%b rdy=%b busy=%b, want 0 1 0", nm, syn_valid, in_ready, busy);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    asserts++;
    if (in_ready !== 1'b1 || syn_valid !== 1'b0 || syn_data !== '0 || syn_zero !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL %s: rdy=%b valid=%b data=%h zero=%b busy=%b, want 1 0 0 0 0",
                        nm, in_ready, syn_valid, syn_data, syn_zero, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    check_reset_vals("reset_state");
  endtask

  task automatic test_all_zero();
    send(15'h0000, N, 0, N, 0);
    asserts++;
    if (syn_valid !== 1'b1) begin fails++; $display("FAIL zero_latency: syn_valid=%b on cycle 16, want 1", syn_valid); end
    collect(0, "all_zero");
  endtask

  task automatic test_first_bit();
    send(15'h4000, N, 0, N, 0);
    for (int k = 0; k < 40 && syn_valid !== 1'b1; k++) tick();
    asserts++;
    if (syn_data[12:0] !== 13'h0036) begin fails++; $display("FAIL first_bit_s1: got %h want 0036", syn_data[12:0]); end
    collect(0, "first_bit");
  endtask

  task automatic test_last_bit();
    send(15'h0001, N, 0, N, 0);
    for (int k = 0; k < 40 && syn_valid !== 1'b1; k++) tick();
    for (int j = 0; j < 8; j++) begin
      asserts++;
      if (syn_data[13*j +: 13] !== 13'h0001) begin
        fails++; $display("FAIL last_bit_s%0d: got %h want 0001", j + 1, syn_data[13*j +: 13]);
      end
    end
    collect(0, "last_bit");
  endtask

  task automatic test_stall();
    send(15'h5a3c, N, 0, N, 0);
    collect(5, "stall");
  endtask

  task automatic test_gaps_reset();
    send(15'h4000, N, 1, N, 0);
    collect(2, "gaps_frame");
    for (int i = 0; i < 7; i++) begin in_valid = 1; in_bit = i[0]; tick(); end
    in_valid = 0; rst = 1; tick(); rst = 0;
    check_reset_vals("mid_frame_reset");
    send(15'h0001, N, 0, N, 0);
    collect(0, "after_reset");
  endtask

  task automatic test_back_to_back();
    send(15'h7fff, N, 0, N, 0);
    collect(0, "b2b_a");
    send(15'h1234, N, 1, N, 0);
    collect(1, "b2b_b");
  endtask

`ifdef BCH_SYN_LAST_CHECK_EN
  task automatic test_last_check();
    send(15'h0201, 10, 0, 10, 1);
    collect(0, "early_last");
    send(15'h0201, N, 0, N, 0);
    collect(0, "good_last");
  endtask
`endif

  initial begin
    pw[0] = 13'h0001;
    for (int k = 1; k < 8191; k++) pw[k] = {pw[k-1][11:0], 1'b0} ^ (pw[k-1][12] ? 13'h001B : 13'h0000);
    test_reset();
    test_all_zero();
    test_first_bit();
    test_last_bit();
    test_stall();
    test_gaps_reset();
    test_back_to_back();
`ifdef BCH_SYN_LAST_CHECK_EN
    test_last_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
